// File: rtl/ic_mem_sched.sv
// I-cache refill scheduler: xid allocation, duplicate-line merging and out-of-order fill matching.
// Optional IC_MEM_SCHED_STATS_EN adds saturating event counters.
module ic_mem_sched #(
    parameter int unsigned NXID   = 4,
    parameter int unsigned PF_MAX = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dm_req,
    input  logic [26:4]   dm_addr,
    output logic          dm_gnt,
    input  logic          pf_req,
    input  logic [26:4]   pf_addr,
    output logic          pf_gnt,
    output logic [26:4]   ic_mem_addr,
    output logic [1:0]    ic_mem_xid,
    output logic          ic_mem_re,
    input  logic          mem_ic_ready,
    input  logic          mem_ic_valid,
    input  logic [1:0]    mem_ic_xid,
    input  logic [127:0]  mem_ic_data,
    output logic          fill_valid,
    output logic [26:4]   fill_addr,
    output logic [127:0]  fill_data,
    output logic          fill_demand,
    output logic          sched_busy
`ifdef IC_MEM_SCHED_STATS_EN
    ,
    output logic [15:0]   stat_dm,
    output logic [15:0]   stat_pf,
    output logic [15:0]   stat_merge,
    output logic [15:0]   stat_orphan
`endif
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e        state_q, state_d;
    logic [3:0]    valid_q, dem_q, pf_q;
    logic [26:4]   addr_q [4];

    logic          re_q;
    logic [26:4]   mem_addr_q;
    logic [1:0]    mem_xid_q;
    logic          fill_valid_q, fill_demand_q;
    logic [26:4]   fill_addr_q;
    logic [127:0]  fill_data_q;

    logic [3:0]    dm_match, pf_match, upgrade;
    int unsigned   free_cnt, pf_cnt;
    logic [1:0]    alloc_idx;
    logic          found;
    logic          alloc, alloc_dem, merge;
    logic [26:4]   alloc_addr;
    logic          resp_hit;

    // Entries at index >= NXID are never allocated, so their valid bit stays 0.
    always_comb begin
        dm_match  = '0;
        pf_match  = '0;
        free_cnt  = 0;
        pf_cnt    = 0;
        alloc_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dm_match[i] = valid_q[i] && (addr_q[i] == dm_addr);
            pf_match[i] = valid_q[i] && (addr_q[i] == pf_addr);
            if (valid_q[i] && pf_q[i]) begin
                pf_cnt = pf_cnt + 1;
            end
        end
        for (int unsigned i = 0; i < NXID; i++) begin
            if (!valid_q[i]) begin
                free_cnt = free_cnt + 1;
                if (!found) begin
                    found     = 1'b1;
                    alloc_idx = 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dm_gnt     = 1'b0;
        pf_gnt     = 1'b0;
        alloc      = 1'b0;
        alloc_dem  = 1'b0;
        merge      = 1'b0;
        upgrade    = '0;
        alloc_addr = dm_addr;
        unique case (state_q)
            StIdle: begin
                if (dm_req) begin
                    if (|dm_match) begin
                        dm_gnt  = 1'b1;
                        merge   = 1'b1;
                        upgrade = dm_match;
                    end else if (free_cnt != 0) begin
                        dm_gnt    = 1'b1;
                        alloc     = 1'b1;
                        alloc_dem = 1'b1;
                        state_d   = StReq;
                    end
                end else if (pf_req) begin
                    alloc_addr = pf_addr;
                    if (|pf_match) begin
                        pf_gnt = 1'b1;
                        merge  = 1'b1;
                    // Keep one entry in reserve so a demand miss can always allocate.
                    end else if (pf_cnt < PF_MAX && free_cnt >= 2) begin
                        pf_gnt  = 1'b1;
                        alloc   = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (re_q && mem_ic_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_hit = mem_ic_valid && valid_q[mem_ic_xid];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            valid_q       <= '0;
            dem_q         <= '0;
            pf_q          <= '0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
            end
            re_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_xid_q     <= '0;
            fill_valid_q  <= 1'b0;
            fill_addr_q   <= '0;
            fill_data_q   <= '0;
            fill_demand_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (alloc) begin
                re_q       <= 1'b1;
                mem_addr_q <= alloc_addr;
                mem_xid_q  <= alloc_idx;
            end else if (re_q && mem_ic_ready) begin
                re_q <= 1'b0;
            end
            dem_q <= dem_q | upgrade;
            if (alloc) begin
                valid_q[alloc_idx] <= 1'b1;
                addr_q[alloc_idx]  <= alloc_addr;
                dem_q[alloc_idx]   <= alloc_dem;
                pf_q[alloc_idx]    <= !alloc_dem;
            end
            fill_valid_q <= resp_hit;
            if (resp_hit) begin
                fill_addr_q         <= addr_q[mem_ic_xid];
                fill_data_q         <= mem_ic_data;
                fill_demand_q       <= dem_q[mem_ic_xid] | upgrade[mem_ic_xid];
                valid_q[mem_ic_xid] <= 1'b0;
            end
        end
    end

    assign ic_mem_re   = re_q;
    assign ic_mem_addr = mem_addr_q;
    assign ic_mem_xid  = mem_xid_q;
    assign fill_valid  = fill_valid_q;
    assign fill_addr   = fill_addr_q;
    assign fill_data   = fill_data_q;
    assign fill_demand = fill_demand_q;
    assign sched_busy  = |valid_q;

`ifdef IC_MEM_SCHED_STATS_EN
    logic [15:0] stat_dm_q, stat_pf_q, stat_merge_q, stat_orphan_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_dm_q     <= '0;
            stat_pf_q     <= '0;
            stat_merge_q  <= '0;
            stat_orphan_q <= '0;
        end else begin
            if (alloc && alloc_dem && stat_dm_q != 16'hFFFF) begin
                stat_dm_q <= stat_dm_q + 16'd1;
            end
            if (alloc && !alloc_dem && stat_pf_q != 16'hFFFF) begin
                stat_pf_q <= stat_pf_q + 16'd1;
            end
            if (merge && stat_merge_q != 16'hFFFF) begin
                stat_merge_q <= stat_merge_q + 16'd1;
            end
            if (mem_ic_valid && !resp_hit && stat_orphan_q != 16'hFFFF) begin
                stat_orphan_q <= stat_orphan_q + 16'd1;
            end
        end
    end

    assign stat_dm     = stat_dm_q;
    assign stat_pf     = stat_pf_q;
    assign stat_merge  = stat_merge_q;
    assign stat_orphan = stat_orphan_q;
`endif

endmodule

// File: tb/tb_ic_mem_sched.sv
// Directed, table-driven bench for ic_mem_sched (NXID=4, PF_MAX=2).
module tb_ic_mem_sched;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dm_req, pf_req;
    logic [26:4]   dm_addr, pf_addr;
    logic          dm_gnt, pf_gnt;
    logic [26:4]   ic_mem_addr;
    logic [1:0]    ic_mem_xid;
    logic          ic_mem_re;
    logic          mem_ic_ready, mem_ic_valid;
    logic [1:0]    mem_ic_xid;
    logic [127:0]  mem_ic_data;
    logic          fill_valid, fill_demand, sched_busy;
    logic [26:4]   fill_addr;
    logic [127:0]  fill_data;
`ifdef IC_MEM_SCHED_STATS_EN
    logic [15:0]   stat_dm, stat_pf, stat_merge, stat_orphan;
`endif

    always #5 clk = ~clk;

    ic_mem_sched #(.NXID(4), .PF_MAX(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dm_req       (dm_req),
        .dm_addr      (dm_addr),
        .dm_gnt       (dm_gnt),
        .pf_req       (pf_req),
        .pf_addr      (pf_addr),
        .pf_gnt       (pf_gnt),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_xid   (ic_mem_xid),
        .ic_mem_re    (ic_mem_re),
        .mem_ic_ready (mem_ic_ready),
        .mem_ic_valid (mem_ic_valid),
        .mem_ic_xid   (mem_ic_xid),
        .mem_ic_data  (mem_ic_data),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_demand  (fill_demand),
        .sched_busy   (sched_busy)
`ifdef IC_MEM_SCHED_STATS_EN
        ,
        .stat_dm      (stat_dm),
        .stat_pf      (stat_pf),
        .stat_merge   (stat_merge),
        .stat_orphan  (stat_orphan)
`endif
    );

    typedef struct {
        logic        dm;
        logic [22:0] da;
        logic        pf;
        logic [22:0] pa;
        logic        rdy;
        logic        rv;
        logic [1:0]  rx;
        logic [7:0]  rb;
        logic        e_dg;
        logic        e_pg;
        logic        e_re;
        logic [1:0]  e_xid;
        logic [22:0] e_ma;
        logic        e_fv;
        logic [22:0] e_fa;
        logic        e_fd;
        logic [7:0]  e_fb;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic dm, input logic [22:0] da, input logic pf, input logic [22:0] pa,
        input logic rdy, input logic rv, input logic [1:0] rx, input logic [7:0] rb,
        input logic dg, input logic pg, input logic re, input logic [1:0] xid,
        input logic [22:0] ma, input logic fv, input logic [22:0] fa, input logic fd,
        input logic [7:0] fb, input logic busy);
        vec_t v;
        v.dm = dm;  v.da = da;   v.pf = pf;   v.pa = pa;   v.rdy = rdy;
        v.rv = rv;  v.rx = rx;   v.rb = rb;
        v.e_dg = dg; v.e_pg = pg; v.e_re = re; v.e_xid = xid; v.e_ma = ma;
        v.e_fv = fv; v.e_fa = fa; v.e_fd = fd; v.e_fb = fb; v.e_busy = busy;
        return v;
    endfunction

    task automatic drive(input logic dm, input logic [22:0] da, input logic pf,
                         input logic [22:0] pa, input logic rdy, input logic rv,
                         input logic [1:0] rx, input logic [7:0] rb);
        dm_req       = dm;
        dm_addr      = da;
        pf_req       = pf;
        pf_addr      = pa;
        mem_ic_ready = rdy;
        mem_ic_valid = rv;
        mem_ic_xid   = rx;
        mem_ic_data  = {16{rb}};
    endtask

    initial begin
        //      dm da      pf pa      rdy rv rx rb     dg pg re xid ma      fv fa      fd fb    busy
        // Basic demand miss, issue, fill.
        vq.push_back(mk(1, 'h100, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    0));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 0, 'h100,  0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 0, 'hA5,  0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      1, 'h100, 1, 'hA5, 0));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0,     0, 0,    0));
        // Memory back-pressure: request held stable, no grants while waiting.
        vq.push_back(mk(1, 'h300, 0, 0,     0, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    0));
        for (int k = 0; k < 5; k++) begin
            vq.push_back(mk(1, 'h301, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, 0, 'h300,  0, 0,     0, 0,    1));
        end
        vq.push_back(mk(1, 'h301, 1, 'h400, 1, 0, 0, 0,     0, 0, 1, 0, 'h300,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h301, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 1, 'h301,  0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 1, 'h11,  0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 0, 'h00,  0, 0, 0, 0, 0,      1, 'h301, 1, 'h11, 1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      1, 'h300, 1, 'h00, 0));
        // Prefetch outstanding, later demand for same line merges and upgrades.
        vq.push_back(mk(0, 0,     1, 'h200, 1, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0, 0,    0));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 0, 'h200,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h200, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 0, 'h22,  0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      1, 'h200, 1, 'h22, 0));
        // Upgrade in the same cycle as the response.
        vq.push_back(mk(0, 0,     1, 'h210, 1, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0, 0,    0));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 0, 'h210,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h210, 0, 0,     1, 1, 0, 'h33,  1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      1, 'h210, 1, 'h33, 0));
        // Prefetch limit, demand reserve, full table, out-of-order drain.
        vq.push_back(mk(0, 0,     1, 'h500, 1, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0, 0,    0));
        vq.push_back(mk(0, 0,     1, 'h501, 1, 0, 0, 0,     0, 0, 1, 0, 'h500,  0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     1, 'h501, 1, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     1, 'h502, 1, 0, 0, 0,     0, 0, 1, 1, 'h501,  0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     1, 'h500, 1, 0, 0, 0,     0, 1, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     1, 'h502, 1, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h600, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 2, 'h600,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h601, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 3, 'h601,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h602, 0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h602, 0, 0,     1, 1, 2, 'h44,  0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h602, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      1, 'h600, 1, 'h44, 1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 2, 'h602,  0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 2, 'h55,  0, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 0, 'h66,  0, 0, 0, 0, 0,      1, 'h602, 1, 'h55, 1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 3, 'h77,  0, 0, 0, 0, 0,      1, 'h500, 0, 'h66, 1));
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 1, 'h88,  0, 0, 0, 0, 0,      1, 'h601, 1, 'h77, 1));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 0, 0, 0,      1, 'h501, 0, 'h88, 0));
        // Orphan response: no fill.
        vq.push_back(mk(0, 0,     0, 0,     1, 1, 3, 'h99,  0, 0, 0, 0, 0,      0, 0,     0, 0,    0));
        // Two demands outstanding, second left waiting on the memory port.
        vq.push_back(mk(1, 'h700, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    0));
        vq.push_back(mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0, 1, 0, 'h700,  0, 0,     0, 0,    1));
        vq.push_back(mk(1, 'h701, 0, 0,     1, 0, 0, 0,     1, 0, 0, 0, 0,      0, 0,     0, 0,    1));
        vq.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0,     0, 0, 1, 1, 'h701,  0, 0,     0, 0,    1));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset dm_gnt", dm_gnt, 0);
        chk("reset pf_gnt", pf_gnt, 0);
        chk("reset ic_mem_re", ic_mem_re, 0);
        chk("reset ic_mem_addr", ic_mem_addr, 0);
        chk("reset ic_mem_xid", ic_mem_xid, 0);
        chk("reset fill_valid", fill_valid, 0);
        chk("reset fill_addr", fill_addr, 0);
        chk("reset fill_data", fill_data, 0);
        chk("reset fill_demand", fill_demand, 0);
        chk("reset sched_busy", sched_busy, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vq[i].dm, vq[i].da, vq[i].pf, vq[i].pa, vq[i].rdy, vq[i].rv, vq[i].rx,
                  vq[i].rb);
            #1;
            chk($sformatf("row%0d dm_gnt", i), dm_gnt, vq[i].e_dg);
            chk($sformatf("row%0d pf_gnt", i), pf_gnt, vq[i].e_pg);
            chk($sformatf("row%0d ic_mem_re", i), ic_mem_re, vq[i].e_re);
            chk($sformatf("row%0d fill_valid", i), fill_valid, vq[i].e_fv);
            chk($sformatf("row%0d sched_busy", i), sched_busy, vq[i].e_busy);
            if (vq[i].e_re) begin
                chk($sformatf("row%0d ic_mem_xid", i), ic_mem_xid, vq[i].e_xid);
                chk($sformatf("row%0d ic_mem_addr", i), ic_mem_addr, vq[i].e_ma);
            end
            if (vq[i].e_fv) begin
                chk($sformatf("row%0d fill_addr", i), fill_addr, vq[i].e_fa);
                chk($sformatf("row%0d fill_demand", i), fill_demand, vq[i].e_fd);
                chk($sformatf("row%0d fill_data", i), fill_data, {16{vq[i].e_fb}});
            end
        end

`ifdef IC_MEM_SCHED_STATS_EN
        chk("stat_dm before reset", stat_dm, 8);
        chk("stat_pf before reset", stat_pf, 4);
        chk("stat_merge before reset", stat_merge, 3);
        chk("stat_orphan before reset", stat_orphan, 1);
`endif

        // Synchronous reset while an issue is pending and two xids are live.
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre-reset ic_mem_re", ic_mem_re, 1);
        chk("pre-reset sched_busy", sched_busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 0, 'hC0);
        #1;
        chk("post-reset ic_mem_re", ic_mem_re, 0);
        chk("post-reset sched_busy", sched_busy, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 1, 'hC1);
        #1;
        chk("stale rsp0 fill_valid", fill_valid, 0);
        @(negedge clk);
        drive(1, 'h800, 0, 0, 1, 0, 0, 0);
        #1;
        chk("stale rsp1 fill_valid", fill_valid, 0);
        chk("post-reset dm_gnt", dm_gnt, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("post-reset ic_mem_re", ic_mem_re, 1);
        chk("post-reset ic_mem_xid", ic_mem_xid, 0);
        chk("post-reset ic_mem_addr", ic_mem_addr, 'h800);
        chk("post-reset fill_valid", fill_valid, 0);
`ifdef IC_MEM_SCHED_STATS_EN
        chk("stat_dm after reset", stat_dm, 1);
        chk("stat_pf after reset", stat_pf, 0);
        chk("stat_merge after reset", stat_merge, 0);
        chk("stat_orphan after reset", stat_orphan, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
